mmio_uart_logger: RTL and testbench
===================================

// Module: mmio_uart_logger
// PURPOSE
//   Store-snooping debug peripheral placed downstream of the top-level MIPS system. It watches the
//   processor's data-memory write port (memwrite/dataadr/writedata). Every store to one
//   memory-mapped address is queued in a small FIFO and sent out on a UART TX line as 4 bytes.
//   This is passive: the data memory still performs the store, and the CPU is never stalled.
// PARAMETERS
//   MMIO_ADDR     32'h0000_03F0  full 32-bit byte address that triggers a capture
//   DEPTH         8              FIFO depth in words; must be a power of 2 and >= 2
//   CLKS_PER_BIT  16             clk cycles per UART bit (868 for 100 MHz / 115200); >= 2
// PORTS
//   clk        in   1                   system clock, all state changes on posedge
//   rst        in   1                   asynchronous, active-low reset (rst==0 resets)
//   memwrite   in   1                   CPU store strobe; one capture per cycle it is high
//   dataadr    in   32                  CPU data address
//   writedata  in   32                  CPU store data
//   tx         out  1                   UART serial out, 8N1, LSB first, idles high
//   busy       out  1                   high while a frame is being sent or the FIFO is non-empty
//   fifo_full  out  1                   level==DEPTH
//   overflow   out  1                   sticky: a capture was dropped because the FIFO was full
//   level      out  $clog2(DEPTH)+1     number of words queued, excluding the word being sent
// BEHAVIOUR
//   Reset (asynchronous, effective immediately):
//     tx=1, busy=0, fifo_full=0, overflow=0, level=0.
//     FIFO pointers are cleared and the FSM goes to IDLE.
//     Any frame in progress is abandoned and is not resumed after reset.
//   Capture:
//     push = memwrite && (dataadr == MMIO_ADDR).
//     The full 32-bit address is compared; there is no masking.
//     On a push edge, writedata is written to the FIFO.
//     If fifo_full is high before that edge, the word is dropped and overflow is set to 1.
//     This holds even if a pop happens on the same edge.
//     overflow is cleared only by reset.
//   FIFO:
//     Circular buffer; read/write pointers wrap modulo DEPTH.
//     A push and a pop on the same edge, when the FIFO is not full, leave level unchanged.
//   FSM states: IDLE, START, DATA, STOP. Counters: baud cnt, bit idx 0..7, byte idx 0..3.
//     IDLE : tx=1. If level!=0 at an edge: pop the head word into the 32-bit shift register,
//            set byte idx=0, go to START, drive tx=0.
//            tx therefore falls exactly 1 cycle after the edge on which the word was pushed.
//     START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit idx=0.
//     DATA : send bit[bit idx] of the current byte; each bit is held CLKS_PER_BIT cycles.
//            After bit 7, go to STOP.
//     STOP : hold tx=1 for CLKS_PER_BIT cycles.
//            If byte idx<3: byte idx+1 and go straight to START (no extra idle cycle).
//            If byte idx==3: go to IDLE.
//   Byte order is little-endian: writedata[7:0] first, [31:24] last.
//   One word takes 40*CLKS_PER_BIT cycles, plus at least 1 IDLE cycle before the next word.
//   tx is driven from a register and has no glitches.
//   busy = (state!=IDLE) || (level!=0).
// TESTING (bench parameters: CLKS_PER_BIT=4, DEPTH=4, MMIO_ADDR=32'h3F0)
//   1. Store 0x12345678 to 0x3F0.
//      -> tx low 1 cycle later.
//      -> bytes 0x78,0x56,0x34,0x12 decoded, each 8N1 at 4 clk/bit.
//      -> busy drops after 160 cycles; level stays 0.
//   2. Store to 0x3F4, and memwrite=0 with dataadr=0x3F0.
//      -> tx stays 1, busy=0, level=0.
//   3. Six back-to-back stores (values 1..6) to 0x3F0.
//      -> word 1 is sent immediately; words 2..5 are queued.
//      -> fifo_full=1; word 6 is dropped and overflow=1.
//      -> UART output is exactly 1,2,3,4,5.
//   4. While level==4, push 0xAA on the same edge that pops a word.
//      -> 0xAA is dropped, overflow=1, level=3.
//   5. Pull rst low halfway through byte 2 of a frame.
//      -> tx=1 and level=0 immediately; after release, no further bits are sent.
//      -> a new store is transmitted cleanly.
//   6. Two stores 0x01 then 0x02, one cycle apart.
//      -> two 40-bit frames separated by exactly 1 idle-high cycle; busy stays high throughout.

Source files
------------

// File: rtl/mmio_uart_logger.sv
// Passive store snooper: stores to MMIO_ADDR go into a small FIFO and are shifted
// out on an 8N1 UART line as four little-endian bytes per word.
module mmio_uart_logger #(
    parameter logic [31:0] MMIO_ADDR    = 32'h0000_03F0,
    parameter int          DEPTH        = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       memwrite,
    input  logic [31:0]                dataadr,
    input  logic [31:0]                writedata,
    output logic                       tx,
    output logic                       busy,
    output logic                       fifo_full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] count_reg;
    logic          overflow_reg;

    logic [1:0]    state_reg;
    logic [BW-1:0] baud_reg;
    logic [2:0]    bit_reg;
    logic [1:0]    byte_reg;
    logic [31:0]   word_reg;
    logic          tx_reg;

    logic push;
    logic full;
    logic push_ok;
    logic pop;
    logic baud_done;

    assign push      = memwrite && (dataadr == MMIO_ADDR);
    assign full      = (count_reg == LW'(DEPTH));
    assign push_ok   = push && !full;
    assign pop       = (state_reg == IDLE) && (count_reg != '0);
    assign baud_done = (baud_reg == BAUD_LAST);

    // Storage array carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && full) begin
                overflow_reg <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + LW'(1);
                2'b01:   count_reg <= count_reg - LW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            byte_reg  <= '0;
            word_reg  <= '0;
            tx_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        word_reg  <= mem[rd_ptr_reg];
                        byte_reg  <= '0;
                        baud_reg  <= '0;
                        tx_reg    <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_reg  <= '0;
                        bit_reg   <= '0;
                        tx_reg    <= word_reg[{byte_reg, 3'd0}];
                        state_reg <= DATA;
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_reg <= bit_reg + 3'd1;
                            tx_reg  <= word_reg[{byte_reg, bit_reg + 3'd1}];
                        end
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_reg <= '0;
                        // Bytes of one word run back to back; only the last byte returns to IDLE.
                        if (byte_reg == 2'd3) begin
                            state_reg <= IDLE;
                        end else begin
                            byte_reg  <= byte_reg + 2'd1;
                            tx_reg    <= 1'b0;
                            state_reg <= START;
                        end
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign tx        = tx_reg;
    assign busy      = (state_reg != IDLE) || (count_reg != '0);
    assign fifo_full = full;
    assign overflow  = overflow_reg;
    assign level     = count_reg;

endmodule

// File: tb/tb_mmio_uart_logger.sv
// Bench for mmio_uart_logger: directed stores, expected UART bytes queued in a scoreboard
// and checked by an independent serial decoder.
module tb_mmio_uart_logger;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] ADDR  = 32'h0000_03F0;

    logic        clk;
    logic        rst;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic [2:0]  level;

    int total_checks = 0;
    int bad_checks   = 0;
    logic [7:0] exp_q[$];

    mmio_uart_logger #(
        .MMIO_ADDR   (ADDR),
        .DEPTH       (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .tx       (tx),
        .busy     (busy),
        .fifo_full(fifo_full),
        .overflow (overflow),
        .level    (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(w[8*i +: 8]);
        end
    endtask

    // Serial decoder: samples mid-bit on falling clock edges, aborts on reset.
    initial begin
        bit         mon_active = 1'b0;
        int         mon_cnt    = 0;
        logic [7:0] mon_byte   = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == 9*CPB + CPB/2) begin
                    mon_active = 1'b0;
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        $display("uart byte %02h expected %02h", mon_byte, e);
                        check("uart_byte", {24'd0, mon_byte}, {24'd0, e});
                    end
                end else if ((mon_cnt % CPB) == CPB/2 && mon_cnt >= CPB) begin
                    mon_byte[mon_cnt/CPB - 1] = tx;
                end
            end
        end
    end

    task automatic do_reset(input string name);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check({name, "_tx"},       {31'd0, tx},        32'd1);
        check({name, "_level"},    {29'd0, level},     32'd0);
        check({name, "_busy"},     {31'd0, busy},      32'd0);
        check({name, "_overflow"}, {31'd0, overflow},  32'd0);
        check({name, "_full"},     {31'd0, fifo_full}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int lows;
        logic [31:0] t4_words [5];
        t4_words[0] = 32'hA1B2_C3D4;
        t4_words[1] = 32'h00FF_00FF;
        t4_words[2] = 32'h8000_0001;
        t4_words[3] = 32'h5A5A_A5A5;
        t4_words[4] = 32'hFFFF_FFFF;

        rst = 1'b0;
        memwrite = 1'b0;
        dataadr = '0;
        writedata = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_tx",       {31'd0, tx},        32'd1);
        check("rst_busy",     {31'd0, busy},      32'd0);
        check("rst_full",     {31'd0, fifo_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow},  32'd0);
        check("rst_level",    {29'd0, level},     32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: single word.
        $display("store 12345678 to 3f0");
        memwrite = 1'b1; dataadr = ADDR; writedata = 32'h1234_5678;
        expect_word(32'h1234_5678);
        @(negedge clk);
        memwrite = 1'b0;
        check("t1_tx_before", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("t1_tx_start",  {31'd0, tx},    32'd0);
        check("t1_level",     {29'd0, level}, 32'd0);
        repeat (159) @(negedge clk);
        check("t1_busy_last", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_busy_done", {31'd0, busy},  32'd0);
        check("t1_level_end", {29'd0, level}, 32'd0);
        repeat (3) @(negedge clk);
        check("t1_queue_empty", exp_q.size(), 32'd0);

        // Test 2: non-matching address and no strobe.
        $display("store to 3f4, then idle strobe on 3f0");
        memwrite = 1'b1; dataadr = 32'h0000_03F4; writedata = 32'hDEAD_0001;
        @(negedge clk);
        check("t2_level_wrongaddr", {29'd0, level}, 32'd0);
        memwrite = 1'b0; dataadr = ADDR; writedata = 32'hDEAD_0002;
        @(negedge clk);
        check("t2_level_nostrobe", {29'd0, level}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("t2_tx", {31'd0, tx}, 32'd1);

        // Test 3: six back-to-back stores into a depth-4 FIFO.
        for (int v = 1; v <= 6; v++) begin
            $display("store %0d to 3f0", v);
            memwrite = 1'b1; dataadr = ADDR; writedata = v;
            if (v <= 5) expect_word(v);
            @(negedge clk);
        end
        memwrite = 1'b0;
        check("t3_level",    {29'd0, level},     32'd4);
        check("t3_full",     {31'd0, fifo_full}, 32'd1);
        check("t3_overflow", {31'd0, overflow},  32'd1);
        wait_drain("t3", 1000);
        check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Test 4: push on the same edge as a pop while full.
        do_reset("t4_rst");
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            $display("store %08h to 3f0", t4_words[i]);
            memwrite = 1'b1; dataadr = ADDR; writedata = t4_words[i];
            expect_word(t4_words[i]);
            @(negedge clk);
        end
        memwrite = 1'b0;
        repeat (156) @(negedge clk);
        check("t4_level_full", {29'd0, level},    32'd4);
        check("t4_no_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        $display("store 000000aa to 3f0 on pop edge");
        memwrite = 1'b1; writedata = 32'h0000_00AA;
        @(negedge clk);
        memwrite = 1'b0;
        check("t4_level",    {29'd0, level},     32'd3);
        check("t4_overflow", {31'd0, overflow},  32'd1);
        check("t4_full",     {31'd0, fifo_full}, 32'd0);
        wait_drain("t4", 1000);

        // Test 5: reset during byte 2 of a frame.
        $display("store deadbeef to 3f0, reset mid-frame");
        memwrite = 1'b1; dataadr = ADDR; writedata = 32'hDEAD_BEEF;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        @(negedge clk);
        memwrite = 1'b0;
        repeat (99) @(negedge clk);
        do_reset("t5_rst");
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("t5_no_resume", lows, 32'd0);
        check("t5_queue_empty", exp_q.size(), 32'd0);
        $display("store 00a55a0f to 3f0");
        memwrite = 1'b1; writedata = 32'h00A5_5A0F;
        expect_word(32'h00A5_5A0F);
        @(negedge clk);
        memwrite = 1'b0;
        wait_drain("t5", 400);

        // Test 6: two words, frames separated by one idle cycle.
        $display("store 01 then 02 to 3f0");
        memwrite = 1'b1; writedata = 32'h0000_0001;
        expect_word(32'h0000_0001);
        @(negedge clk);
        memwrite = 1'b0;
        @(negedge clk);
        check("t6_start1", {31'd0, tx}, 32'd0);
        memwrite = 1'b1; writedata = 32'h0000_0002;
        expect_word(32'h0000_0002);
        @(negedge clk);
        memwrite = 1'b0;
        lows = 0;
        for (int cyc = 3; cyc <= 323; cyc++) begin
            if (cyc == 161) check("t6_stop",   {31'd0, tx}, 32'd1);
            if (cyc == 162) check("t6_gap",    {31'd0, tx}, 32'd1);
            if (cyc == 163) check("t6_start2", {31'd0, tx}, 32'd0);
            if (cyc <= 322 && !busy) lows++;
            if (cyc == 323) check("t6_busy_done", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        check("t6_busy_held", lows, 32'd0);
        repeat (3) @(negedge clk);
        check("t6_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
